// File: rtl/sti_pkg.sv
// Shared definitions for the STI serial link (transmitter and receiver).
package sti_pkg;

    // Frame length codes carried on cfg_length.
    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_24 = 2'b10;
    localparam logic [1:0] LEN_32 = 2'b11;

    // Receiver/transmitter FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    // Number of serial bits in a frame for a given length code: 8, 16, 24 or 32.
    function automatic logic [5:0] frame_bits(input logic [1:0] len);
        return {1'b0, len, 3'b000} + 6'd8;
    endfunction

endpackage

// File: rtl/sti_rx_extract.sv
// Pulls the 16-bit payload and the padding check out of an assembled frame word.
module sti_rx_extract
    import sti_pkg::*;
(
    input  logic [31:0] w,
    input  logic [1:0]  length,
    input  logic        fill,
    input  logic        low,
    output logic [15:0] data,
    output logic        pad_err
);

    // Select payload and padding field according to the frame layout.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data    = w[15:0];
        pad_err = 1'b0;
        case (length)
            LEN_8: begin
                data = low ? {w[7:0], 8'h00} : {8'h00, w[7:0]};
            end
            LEN_16: begin
                data = w[15:0];
            end
            LEN_24: begin
                if (fill) begin
                    data    = w[23:8];
                    pad_err = |w[7:0];
                end else begin
                    data    = w[15:0];
                    pad_err = |w[23:16];
                end
            end
            LEN_32: begin
                if (fill) begin
                    data    = w[31:16];
                    pad_err = |w[15:0];
                end else begin
                    data    = w[15:0];
                    pad_err = |w[31:16];
                end
            end
            default: begin
                data    = w[15:0];
                pad_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sti_rx.sv
// STI serial receiver: deserialises 8/16/24/32-bit frames into a 16-bit word,
// flags padding errors, truncated frames and the end-of-stream frame.
module sti_rx
    import sti_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             si_data,
    input  logic             si_valid,
    input  logic [1:0]       cfg_length,
    input  logic             cfg_msb,
    input  logic             cfg_fill,
    input  logic             cfg_low,
    input  logic             si_end,
    output logic [15:0]      po_data,
    output logic             po_valid,
    output logic             po_pad_err,
    output logic             po_trunc,
    output logic             rx_done,
    output logic [CNT_W-1:0] rx_count
);

    state_t      state;
    logic [31:0] w;
    logic [5:0]  bit_cnt;
    logic [1:0]  len_q;
    logic        msb_q;
    logic        fill_q;
    logic        low_q;
    logic        frame_rdy;
    logic        frame_end;

    logic        start;
    logic        shift_in;
    logic        last_bit;
    logic [1:0]  len_use;
    logic        msb_use;
    logic [5:0]  n_use;
    logic [31:0] w_base;
    logic [31:0] w_next;
    logic [15:0] ex_data;
    logic        ex_pad;

    // Next frame word: the first bit of a frame uses the live cfg and a cleared word,
    // later bits use the cfg latched at frame start.
    always_comb begin
        start    = si_valid && (state == IDLE);
        shift_in = si_valid && (state == SHIFT);
        len_use  = start ? cfg_length : len_q;
        msb_use  = start ? cfg_msb    : msb_q;
        n_use    = frame_bits(len_use);
        w_base   = start ? 32'h0 : w;
        if (msb_use)
            w_next = {w_base[30:0], si_data};
        else
            w_next = (w_base >> 1) | ({31'h0, si_data} << (n_use - 6'd1));
        last_bit = shift_in && ((bit_cnt + 6'd1) == frame_bits(len_q));
    end

    sti_rx_extract u_extract (
        .w       (w),
        .length  (len_q),
        .fill    (fill_q),
        .low     (low_q),
        .data    (ex_data),
        .pad_err (ex_pad)
    );

    // FSM, shifter, output register and frame counter.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every read in this block sees pre-edge values.
        if (reset) begin
            // NOTE: the frame word and latched cfg are reset too, so a partial frame never leaks out.
            state      <= IDLE;
            w          <= '0;
            bit_cnt    <= '0;
            len_q      <= LEN_8;
            msb_q      <= 1'b0;
            fill_q     <= 1'b0;
            low_q      <= 1'b0;
            frame_rdy  <= 1'b0;
            frame_end  <= 1'b0;
            po_data    <= '0;
            po_valid   <= 1'b0;
            po_pad_err <= 1'b0;
            po_trunc   <= 1'b0;
            rx_done    <= 1'b0;
            rx_count   <= '0;
        end else begin
            po_valid  <= frame_rdy;
            po_trunc  <= 1'b0;
            frame_rdy <= 1'b0;

            // Publish the frame completed on the previous edge; w and cfg still hold it
            // even if a back-to-back frame starts on this edge.
            if (frame_rdy) begin
                po_data    <= ex_data;
                po_pad_err <= ex_pad;
                if (frame_end)
                    rx_done <= 1'b1;
                if (rx_count != {CNT_W{1'b1}})
                    rx_count <= rx_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= cfg_length;
                        msb_q   <= cfg_msb;
                        fill_q  <= cfg_fill;
                        low_q   <= cfg_low;
                        w       <= w_next;
                        bit_cnt <= 6'd1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_in) begin
                        w       <= w_next;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (last_bit) begin
                            frame_rdy <= 1'b1;
                            frame_end <= si_end;
                            bit_cnt   <= '0;
                            state     <= si_end ? DONE : IDLE;
                        end
                    end else begin
                        po_trunc <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= IDLE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sti_rx.sv
// Directed self-checking bench for the STI serial receiver.
module tb_sti_rx;
    import sti_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        si_data;
    logic        si_valid;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic        cfg_fill;
    logic        cfg_low;
    logic        si_end;
    logic [15:0] po_data;
    logic        po_valid;
    logic        po_pad_err;
    logic        po_trunc;
    logic        rx_done;
    logic [7:0]  rx_count;

    sti_rx #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .cfg_length (cfg_length),
        .cfg_msb    (cfg_msb),
        .cfg_fill   (cfg_fill),
        .cfg_low    (cfg_low),
        .si_end     (si_end),
        .po_data    (po_data),
        .po_valid   (po_valid),
        .po_pad_err (po_pad_err),
        .po_trunc   (po_trunc),
        .rx_done    (rx_done),
        .rx_count   (rx_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_cyc = 0;
    int trunc_cnt = 0;
    int both_cnt  = 0;
    logic [15:0] v_data[$];
    logic        v_pad[$];
    logic        v_done[$];
    int          v_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (po_valid) begin
            v_data.push_back(po_data);
            v_pad.push_back(po_pad_err);
            v_done.push_back(rx_done);
            v_cyc.push_back(cyc);
        end
        if (po_trunc) trunc_cnt++;
        if (po_valid && po_trunc) both_cnt++;
    end

    task automatic clear_log();
        v_data.delete();
        v_pad.delete();
        v_done.delete();
        v_cyc.delete();
        trunc_cnt = 0;
    endtask

    // end_mode: 0 none, 1 si_end on final bit, 2 si_end on first bit only.
    // cfg inputs are scrambled after the first bit to show they are ignored mid-frame.
    task automatic send_frame(input logic [31:0] word, input logic [1:0] len, input logic msb,
                              input logic fill, input logic low, input int end_mode);
        int n;
        n = 8 * (int'(len) + 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            si_valid   = 1'b1;
            si_data    = msb ? word[n-1-i] : word[i];
            cfg_length = (i == 0) ? len  : ~len;
            cfg_msb    = (i == 0) ? msb  : ~msb;
            cfg_fill   = (i == 0) ? fill : ~fill;
            cfg_low    = (i == 0) ? low  : ~low;
            si_end     = (end_mode == 1 && i == n-1) || (end_mode == 2 && i == 0);
            last_cyc   = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            si_valid = 1'b0;
            si_end   = 1'b0;
            si_data  = 1'b0;
        end
    endtask

    task automatic check_word(input string tag, input int idx, input logic [15:0] exp_data,
                              input logic exp_pad);
        if (idx < v_data.size()) begin
            check({tag, "_data"}, 32'(v_data[idx]), 32'(exp_data));
            check({tag, "_pad"}, 32'(v_pad[idx]), 32'(exp_pad));
        end else begin
            check({tag, "_present"}, v_data.size(), idx + 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        si_valid = 1'b0;
        si_end   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; si_data = 1'b0; si_valid = 1'b0; si_end = 1'b0;
        cfg_length = LEN_8; cfg_msb = 1'b0; cfg_fill = 1'b0; cfg_low = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_data",  32'(po_data), 0);
        check("rst_valid", 32'(po_valid), 0);
        check("rst_count", 32'(rx_count), 0);
        check("rst_done",  32'(rx_done), 0);

        // 1: 16-bit MSB-first, latency of two edges after the last bit.
        clear_log();
        send_frame(32'h0000A5C3, LEN_16, 1'b1, 1'b0, 1'b0, 0);
        idle(4);
        check("t1_nvalid", v_data.size(), 1);
        check_word("t1", 0, 16'hA5C3, 1'b0);
        if (v_cyc.size() > 0) check("t1_latency", v_cyc[0] - last_cyc, 2);
        check("t1_count", 32'(rx_count), 1);

        // 2: 8-bit LSB-first, high and low byte placement; si_end on first bit ignored.
        clear_log();
        send_frame(32'h3C, LEN_8, 1'b0, 1'b0, 1'b1, 2);
        idle(3);
        send_frame(32'h3C, LEN_8, 1'b0, 1'b0, 1'b0, 0);
        idle(3);
        check_word("t2_hi", 0, 16'h3C00, 1'b0);
        check_word("t2_lo", 1, 16'h003C, 1'b0);
        check("t2_done", 32'(rx_done), 0);
        check("t2_count", 32'(rx_count), 3);

        // 3: 32-bit fill=0, clean padding then nonzero padding.
        clear_log();
        send_frame(32'h0000BEEF, LEN_32, 1'b1, 1'b0, 1'b0, 0);
        idle(3);
        send_frame(32'h0001BEEF, LEN_32, 1'b1, 1'b0, 1'b0, 0);
        idle(3);
        check_word("t3_ok", 0, 16'hBEEF, 1'b0);
        check_word("t3_pad", 1, 16'hBEEF, 1'b1);

        // 4: 24-bit fill=1 back-to-back frames.
        clear_log();
        send_frame(32'h00123400, LEN_24, 1'b1, 1'b1, 1'b0, 0);
        send_frame(32'h00567800, LEN_24, 1'b1, 1'b1, 1'b0, 0);
        idle(4);
        check("t4_nvalid", v_data.size(), 2);
        check_word("t4_a", 0, 16'h1234, 1'b0);
        check_word("t4_b", 1, 16'h5678, 1'b0);
        if (v_cyc.size() > 1) check("t4_gap", v_cyc[1] - v_cyc[0], 24);
        check("t4_count", 32'(rx_count), 7);

        // 5: truncated frame, then reset in the middle of a frame.
        clear_log();
        begin
            logic [31:0] w16;
            w16 = 32'h0000FFFF;
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                si_valid = 1'b1; si_data = w16[i]; cfg_length = LEN_16; cfg_msb = 1'b0;
            end
        end
        idle(4);
        check("t5_trunc", trunc_cnt, 1);
        check("t5_nvalid", v_data.size(), 0);
        check("t5_count", 32'(rx_count), 7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            si_valid = 1'b1; si_data = 1'b1; cfg_length = LEN_16; cfg_msb = 1'b1;
        end
        do_reset();
        idle(20);
        check("t5_rst_data",  32'(po_data), 0);
        check("t5_rst_pad",   32'(po_pad_err), 0);
        check("t5_rst_trunc", trunc_cnt, 1);
        check("t5_rst_count", 32'(rx_count), 0);
        check("t5_rst_valid", v_data.size(), 0);

        // Counter saturation: 256 back-to-back 8-bit frames.
        clear_log();
        for (int i = 0; i < 256; i++)
            send_frame(32'(i), LEN_8, 1'b0, 1'b0, 1'b0, 0);
        idle(4);
        check("sat_nvalid", v_data.size(), 256);
        check_word("sat_last", 255, 16'h00FF, 1'b0);
        check("sat_count", 32'(rx_count), 255);

        // 6: end-of-stream frame, later frames ignored until reset.
        do_reset();
        clear_log();
        send_frame(32'h5A, LEN_8, 1'b1, 1'b0, 1'b0, 1);
        idle(3);
        check_word("t6", 0, 16'h005A, 1'b0);
        if (v_done.size() > 0) check("t6_done_with_valid", 32'(v_done[0]), 1);
        send_frame(32'h11, LEN_8, 1'b1, 1'b0, 1'b0, 0);
        idle(4);
        check("t6_nvalid", v_data.size(), 1);
        check("t6_done_sticky", 32'(rx_done), 1);
        check("t6_count", 32'(rx_count), 1);
        do_reset();
        @(negedge clk);
        check("t6_rst_done", 32'(rx_done), 0);

        check("never_both", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
